// File: rtl/wb_stage_pkg.sv
// Shared TinyCPU writeback definitions.
// Load-op encodings, datapath defaults and the MEM->WB bundle field order.
package wb_stage_pkg;

  localparam int XLEN_D = 32;
  localparam int RA_W_D = 5;

  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LH  = 3'd1,
    LD_LW  = 3'd2,
    LD_LBU = 3'd4,
    LD_LHU = 3'd5
  } ld_op_e;

  // Field order the MEM stage uses when packing the WB inputs.
  typedef struct packed {
    logic [XLEN_D-1:0] pc;
    logic              wen;
    logic [RA_W_D-1:0] wdest;
    logic [XLEN_D-1:0] result;
    logic              ld;
    logic [2:0]        ld_op;
    logic [1:0]        ld_off;
  } mem2wb_t;

endpackage

// File: rtl/wb_load_align.sv
// Load-data extraction: byte/half/word select with sign or zero extension.
// Ports: word (raw memory word), ld_op, ld_off -> data (extracted value).
module wb_load_align
  import wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] word,
  input  logic [2:0]      ld_op,
  input  logic [1:0]      ld_off,
  output logic [XLEN-1:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = 8'(word >> {ld_off, 3'b000});
    h = ld_off[1] ? word[16 +: 16] : word[15:0];
    data = word;
    case (ld_op)
      LD_LB:   data = {{(XLEN-8){b[7]}}, b};
      LD_LBU:  data = {{(XLEN-8){1'b0}}, b};
      LD_LH:   data = {{(XLEN-16){h[15]}}, h};
      LD_LHU:  data = {{(XLEN-16){1'b0}}, h};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// TinyCPU writeback stage: payload register, RF write, hazard dest, instret.
// Ports: MEM handshake/payload in, hold/flush, RF write, wb_dest, retire/trace.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int XLEN              = 32,
  parameter int RA_W              = 5,
  parameter int CNT_W             = 64,
  parameter bit ZERO_REG_SUPPRESS = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [XLEN-1:0]  in_pc_i,
  input  logic             in_wen_i,
  input  logic [RA_W-1:0]  in_wdest_i,
  input  logic [XLEN-1:0]  in_result_i,
  input  logic             in_ld_i,
  input  logic [2:0]       in_ld_op_i,
  input  logic [1:0]       in_ld_off_i,
  input  logic             hold_i,
  input  logic             flush_i,
  output logic             rf_wen_o,
  output logic [RA_W-1:0]  rf_wdest_o,
  output logic [XLEN-1:0]  rf_wdata_o,
  output logic [RA_W-1:0]  wb_dest_o,
  output logic             retire_o,
  output logic [XLEN-1:0]  retire_pc_o,
  output logic [CNT_W-1:0] instret_o
);

  logic             valid_q;
  logic             wen_q;
  logic [RA_W-1:0]  wdest_q;
  logic [XLEN-1:0]  data_q;
  logic [XLEN-1:0]  pc_q;
  logic [CNT_W-1:0] instret_q;
  logic [XLEN-1:0]  ld_data;
  logic             accept;
  logic             dest_zero;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .word   (in_result_i),
    .ld_op  (in_ld_op_i),
    .ld_off (in_ld_off_i),
    .data   (ld_data)
  );

  assign dest_zero  = (wdest_q == '0);
  assign in_ready_o = !valid_q || !hold_i;
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign retire_o   = valid_q && !hold_i && !flush_i;
  assign rf_wen_o   = retire_o && wen_q
                   && !(ZERO_REG_SUPPRESS && dest_zero);
  assign rf_wdest_o  = wdest_q;
  assign rf_wdata_o  = data_q;
  assign retire_pc_o = pc_q;
  assign instret_o   = instret_q;
  assign wb_dest_o   = (valid_q && wen_q && !dest_zero)
                     ? wdest_q : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      wen_q     <= 1'b0;
      wdest_q   <= '0;
      data_q    <= '0;
      pc_q      <= '0;
      instret_q <= '0;
    end else begin
      if (flush_i) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        wen_q   <= in_wen_i;
        wdest_q <= in_wdest_i;
        data_q  <= in_ld_i ? ld_data : in_result_i;
        pc_q    <= in_pc_i;
      end else if (retire_o) begin
        valid_q <= 1'b0;
      end
      if (retire_o) begin
        instret_q <= instret_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage (CNT_W=8 so the counter wrap is reachable).
// Stimulus pushes expected retirements; a negedge monitor pops and compares.
module tb_wb_stage;

  localparam int XLEN  = 32;
  localparam int RA_W  = 5;
  localparam int CNT_W = 8;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             in_valid_i;
  logic             in_ready_o;
  logic [XLEN-1:0]  in_pc_i;
  logic             in_wen_i;
  logic [RA_W-1:0]  in_wdest_i;
  logic [XLEN-1:0]  in_result_i;
  logic             in_ld_i;
  logic [2:0]       in_ld_op_i;
  logic [1:0]       in_ld_off_i;
  logic             hold_i;
  logic             flush_i;
  logic             rf_wen_o;
  logic [RA_W-1:0]  rf_wdest_o;
  logic [XLEN-1:0]  rf_wdata_o;
  logic [RA_W-1:0]  wb_dest_o;
  logic             retire_o;
  logic [XLEN-1:0]  retire_pc_o;
  logic [CNT_W-1:0] instret_o;

  wb_stage #(.XLEN(XLEN), .RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_pc_i     (in_pc_i),
    .in_wen_i    (in_wen_i),
    .in_wdest_i  (in_wdest_i),
    .in_result_i (in_result_i),
    .in_ld_i     (in_ld_i),
    .in_ld_op_i  (in_ld_op_i),
    .in_ld_off_i (in_ld_off_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .rf_wen_o    (rf_wen_o),
    .rf_wdest_o  (rf_wdest_o),
    .rf_wdata_o  (rf_wdata_o),
    .wb_dest_o   (wb_dest_o),
    .retire_o    (retire_o),
    .retire_pc_o (retire_pc_o),
    .instret_o   (instret_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            wen;
    logic [RA_W-1:0] dest;
    logic [XLEN-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic [XLEN-1:0] pc_n = 32'h1000;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (retire_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire: pc %0h expected none",
                 retire_pc_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("retire_pc", 64'(retire_pc_o), 64'(e.pc));
        chk("rf_wen", 64'(rf_wen_o), 64'(e.wen));
        chk("rf_wdest", 64'(rf_wdest_o), 64'(e.dest));
        chk("rf_wdata", 64'(rf_wdata_o), 64'(e.data));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Present one item for one cycle; optionally record its retirement.
  task automatic send(input logic wen, input logic [RA_W-1:0] dest,
                      input logic [XLEN-1:0] res, input logic ld,
                      input logic [2:0] op, input logic [1:0] off,
                      input logic [XLEN-1:0] exp_data, input bit push);
    exp_t e;
    in_valid_i  = 1'b1;
    in_pc_i     = pc_n;
    in_wen_i    = wen;
    in_wdest_i  = dest;
    in_result_i = res;
    in_ld_i     = ld;
    in_ld_op_i  = op;
    in_ld_off_i = off;
    if (push) begin
      e.pc   = pc_n;
      e.wen  = wen && (dest != 0);
      e.dest = dest;
      e.data = exp_data;
      exp_q.push_back(e);
    end
    pc_n = pc_n + 4;
    @(negedge clk_i);
    chk("in_ready", 64'(in_ready_o), 64'd1);
    tick();
    in_valid_i = 1'b0;
  endtask

  task automatic alu(input logic [RA_W-1:0] d, input logic [XLEN-1:0] v);
    send(1'b1, d, v, 1'b0, 3'd2, 2'd0, v, 1'b1);
  endtask

  task automatic ld(input logic [2:0] op, input logic [1:0] off,
                    input logic [XLEN-1:0] exp_v);
    send(1'b1, 5'd12, 32'h8070F0A5, 1'b1, op, off, exp_v, 1'b1);
  endtask

  task automatic check_reset_outs();
    @(negedge clk_i);
    chk("rst_rf_wen", 64'(rf_wen_o), 64'd0);
    chk("rst_retire", 64'(retire_o), 64'd0);
    chk("rst_wb_dest", 64'(wb_dest_o), 64'd0);
    chk("rst_ready", 64'(in_ready_o), 64'd1);
    chk("rst_instret", 64'(instret_o), 64'd0);
    chk("rst_wdata", 64'(rf_wdata_o), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    in_valid_i = 1'b0;
    in_pc_i = '0;
    in_wen_i = 1'b0;
    in_wdest_i = '0;
    in_result_i = '0;
    in_ld_i = 1'b0;
    in_ld_op_i = 3'd0;
    in_ld_off_i = 2'd0;
    hold_i = 1'b0;
    flush_i = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;
    check_reset_outs();
    tick();

    // back-to-back ALU writes
    alu(5'd5, 32'h11);
    alu(5'd6, 32'h22);
    alu(5'd7, 32'h33);
    tick();
    @(negedge clk_i);
    chk("instret_b2b", 64'(instret_o), 64'd3);
    tick();

    // load extraction
    ld(3'd0, 2'd0, 32'hFFFFFFA5);
    ld(3'd4, 2'd1, 32'h000000F0);
    ld(3'd1, 2'd2, 32'hFFFF8070);
    ld(3'd5, 2'd0, 32'h0000F0A5);
    ld(3'd2, 2'd3, 32'h8070F0A5);
    ld(3'd7, 2'd1, 32'h8070F0A5);
    ld(3'd5, 2'd3, 32'h00008070);
    tick();
    @(negedge clk_i);
    chk("instret_ld", 64'(instret_o), 64'd10);
    tick();

    // x0 write is dropped but still retires
    send(1'b1, 5'd0, 32'hDEAD, 1'b0, 3'd2, 2'd0, 32'hDEAD, 1'b1);
    @(negedge clk_i);
    chk("x0_wb_dest", 64'(wb_dest_o), 64'd0);
    chk("x0_rf_wen", 64'(rf_wen_o), 64'd0);
    chk("x0_retire", 64'(retire_o), 64'd1);
    tick();
    @(negedge clk_i);
    chk("instret_x0", 64'(instret_o), 64'd11);
    tick();

    // hold for 3 cycles then release straight into the next item
    alu(5'd3, 32'd7);
    hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      chk("hold_ready", 64'(in_ready_o), 64'd0);
      chk("hold_retire", 64'(retire_o), 64'd0);
      chk("hold_wb_dest", 64'(wb_dest_o), 64'd3);
      tick();
    end
    hold_i = 1'b0;
    alu(5'd4, 32'd9);
    tick();
    @(negedge clk_i);
    chk("instret_hold", 64'(instret_o), 64'd13);
    tick();

    // flush while occupied and a new item is offered
    send(1'b1, 5'd8, 32'h55, 1'b0, 3'd2, 2'd0, 32'h55, 1'b0);
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    in_wen_i = 1'b1;
    in_wdest_i = 5'd9;
    in_result_i = 32'h66;
    in_ld_i = 1'b0;
    @(negedge clk_i);
    chk("flush_rf_wen", 64'(rf_wen_o), 64'd0);
    chk("flush_retire", 64'(retire_o), 64'd0);
    tick();
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    chk("postflush_retire", 64'(retire_o), 64'd0);
    chk("postflush_wb_dest", 64'(wb_dest_o), 64'd0);
    chk("instret_flush", 64'(instret_o), 64'd13);
    tick();

    // run instret up to 0xFF, then wrap
    for (int i = 0; i < 242; i++) begin
      alu(5'(1 + (i % 31)), 32'(i));
    end
    tick();
    @(negedge clk_i);
    chk("instret_ff", 64'(instret_o), 64'hFF);
    tick();
    alu(5'd1, 32'hA);
    tick();
    @(negedge clk_i);
    chk("instret_wrap0", 64'(instret_o), 64'h00);
    tick();
    alu(5'd2, 32'hB);
    tick();
    @(negedge clk_i);
    chk("instret_wrap1", 64'(instret_o), 64'h01);
    tick();

    // reset in the middle of a hold
    send(1'b1, 5'd10, 32'h77, 1'b0, 3'd2, 2'd0, 32'h77, 1'b0);
    hold_i = 1'b1;
    @(negedge clk_i);
    chk("prerst_wb_dest", 64'(wb_dest_o), 64'd10);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check_reset_outs();
    tick();
    hold_i = 1'b0;
    tick();
    tick();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_retires: got %0d expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
